// File: rtl/uart_reg_bridge_if.sv
// -----------------------------------------------------------------------------
// uart_reg_bridge_if
// Bundles the UART PHY byte stream and the 8-bit register bus seen by
// uart_reg_bridge.
//   byte_rx/new_byte_rx : received byte and its one-cycle valid strobe
//   done_tx             : PHY transmitter idle
//   byte_tx/start_tx    : reply byte and its one-cycle launch strobe
//   reg_addr/reg_wdata  : register bus address / write data
//   reg_we/reg_re       : one-cycle write / read strobes
//   reg_rdata           : read data, valid the cycle after reg_re
//   frame_err           : one-cycle pulse on a rejected or abandoned frame
//   busy                : bridge is not idle
// master = bridge side, slave = PHY / register-file side.
// -----------------------------------------------------------------------------
interface uart_reg_bridge_if;
   logic [7:0] byte_rx;
   logic       new_byte_rx;
   logic       done_tx;
   logic [7:0] byte_tx;
   logic       start_tx;
   logic [7:0] reg_addr;
   logic [7:0] reg_wdata;
   logic       reg_we;
   logic       reg_re;
   logic [7:0] reg_rdata;
   logic       frame_err;
   logic       busy;

   modport master (
      input  byte_rx, new_byte_rx, done_tx, reg_rdata,
      output byte_tx, start_tx, reg_addr, reg_wdata, reg_we, reg_re,
             frame_err, busy
   );

   modport slave (
      output byte_rx, new_byte_rx, done_tx, reg_rdata,
      input  byte_tx, start_tx, reg_addr, reg_wdata, reg_we, reg_re,
             frame_err, busy
   );
endinterface

// File: rtl/uart_reg_bridge.sv
// -----------------------------------------------------------------------------
// uart_reg_bridge
// Turns 'W' addr data / 'R' addr byte frames from a UART into accesses on an
// 8-bit register bus, answering each frame with one byte: 'K' for a write,
// the register value for a read, 'E' for a rejected frame.
// Ports:
//   clk  : system clock
//   arst : asynchronous active-high reset
//   bus  : uart_reg_bridge_if.master (PHY byte stream + register bus)
// Parameter:
//   timeout_cycles : idle clocks allowed between bytes of one frame
// Build option:
//   UART_BRIDGE_CHECKSUM_EN : frames carry a trailing XOR checksum byte
// -----------------------------------------------------------------------------
module uart_reg_bridge #(
   parameter int unsigned timeout_cycles = 5000000
) (
   input logic             clk,
   input logic             arst,
   uart_reg_bridge_if.master bus
);

   localparam int unsigned CW = (timeout_cycles > 2) ? $clog2(timeout_cycles) : 1;
   localparam logic [CW-1:0] TO_LAST = CW'(timeout_cycles - 1);
   localparam logic [7:0] CMD_W = 8'h57;
   localparam logic [7:0] CMD_R = 8'h52;
   localparam logic [7:0] RSP_K = 8'h4B;
   localparam logic [7:0] RSP_E = 8'h45;

   typedef enum logic [3:0] {
      IDLE, GET_ADDR, GET_DATA, BUS_WR, BUS_RD, RD_CAP, SEND, SEND_HOLD, SEND_WAIT
`ifdef UART_BRIDGE_CHECKSUM_EN
      , GET_CSUM
`endif
   } state_t;

   state_t        state_q, state_d;
   logic          is_wr_q, is_wr_d;
   logic [7:0]    addr_q, addr_d;
   logic [7:0]    wdata_q, wdata_d;
   logic [7:0]    tx_q, tx_d;
   logic          start_q, start_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ferr;
   logic          tmo;
`ifdef UART_BRIDGE_CHECKSUM_EN
   logic [7:0]    csum_q, csum_d;
`endif

   // A byte arriving on the last allowed cycle beats the timeout.
   assign tmo = (cnt_q == TO_LAST) && !bus.new_byte_rx;

   always_comb begin
      state_d = state_q;
      is_wr_d = is_wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      tx_d    = tx_q;
      start_d = 1'b0;
      cnt_d   = '0;
      ferr    = 1'b0;
`ifdef UART_BRIDGE_CHECKSUM_EN
      csum_d  = csum_q;
`endif
      case (state_q)
         IDLE: if (bus.new_byte_rx) begin
            if (bus.byte_rx == CMD_W || bus.byte_rx == CMD_R) begin
               is_wr_d = (bus.byte_rx == CMD_W);
`ifdef UART_BRIDGE_CHECKSUM_EN
               csum_d  = bus.byte_rx;
`endif
               state_d = GET_ADDR;
            end else begin
               tx_d    = RSP_E;
               ferr    = 1'b1;
               state_d = SEND;
            end
         end
         GET_ADDR: begin
            if (bus.new_byte_rx) begin
               addr_d = bus.byte_rx;
`ifdef UART_BRIDGE_CHECKSUM_EN
               csum_d  = csum_q ^ bus.byte_rx;
               state_d = is_wr_q ? GET_DATA : GET_CSUM;
`else
               state_d = is_wr_q ? GET_DATA : BUS_RD;
`endif
            end else if (tmo) begin
               ferr    = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         GET_DATA: begin
            if (bus.new_byte_rx) begin
               wdata_d = bus.byte_rx;
`ifdef UART_BRIDGE_CHECKSUM_EN
               csum_d  = csum_q ^ bus.byte_rx;
               state_d = GET_CSUM;
`else
               state_d = BUS_WR;
`endif
            end else if (tmo) begin
               ferr    = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
`ifdef UART_BRIDGE_CHECKSUM_EN
         GET_CSUM: begin
            if (bus.new_byte_rx) begin
               if (bus.byte_rx == csum_q) begin
                  state_d = is_wr_q ? BUS_WR : BUS_RD;
               end else begin
                  tx_d    = RSP_E;
                  ferr    = 1'b1;
                  state_d = SEND;
               end
            end else if (tmo) begin
               ferr    = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
`endif
         BUS_WR: begin
            tx_d    = RSP_K;
            state_d = SEND;
         end
         BUS_RD:  state_d = RD_CAP;
         RD_CAP: begin
            tx_d    = bus.reg_rdata;
            state_d = SEND;
         end
         SEND: if (bus.done_tx) begin
            start_d = 1'b1;
            state_d = SEND_HOLD;
         end
         // done_tx still reads high here; the PHY drops it one cycle after start.
         SEND_HOLD: state_d = SEND_WAIT;
         SEND_WAIT: if (bus.done_tx) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q <= IDLE;
         is_wr_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         tx_q    <= '0;
         start_q <= 1'b0;
         cnt_q   <= '0;
`ifdef UART_BRIDGE_CHECKSUM_EN
         csum_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         is_wr_q <= is_wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         tx_q    <= tx_d;
         start_q <= start_d;
         cnt_q   <= cnt_d;
`ifdef UART_BRIDGE_CHECKSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

   assign bus.byte_tx   = tx_q;
   assign bus.start_tx  = start_q;
   assign bus.reg_addr  = addr_q;
   assign bus.reg_wdata = wdata_q;
   assign bus.reg_we    = (state_q == BUS_WR);
   assign bus.reg_re    = (state_q == BUS_RD);
   // frame_err is decoded from the current byte/counter; mask it while in reset.
   assign bus.frame_err = ferr & ~arst;
   assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_reg_bridge.sv
module tb_uart_reg_bridge;

   logic clk = 1'b0;
   logic arst = 1'b1;
   int   cyc = 0;

   uart_reg_bridge_if u_if();

   uart_reg_bridge #(.timeout_cycles(100)) dut (
      .clk  (clk),
      .arst (arst),
      .bus  (u_if)
   );

   always #5 clk = ~clk;

   // PHY and register-file models
   int         phy_cnt = 0;
   logic       hold_done = 1'b0;
   logic [7:0] rd_val = 8'h00;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (u_if.start_tx) phy_cnt <= 6;
      else if (phy_cnt != 0) phy_cnt <= phy_cnt - 1;
      u_if.reg_rdata <= u_if.reg_re ? rd_val : 8'h00;
   end
   assign u_if.done_tx = (phy_cnt == 0) && !hold_done;

   // Output monitor, sampled 1 time unit after the falling edge
   int we_n = 0, re_n = 0, tx_n = 0, fe_n = 0, both_n = 0;
   int tx_c = 0, fe_c = 0;
   logic [7:0] we_a = 0, we_d = 0, re_a = 0, tx_b = 0;

   always begin
      @(negedge clk);
      #1;
      if (u_if.reg_we) begin we_n++; we_a = u_if.reg_addr; we_d = u_if.reg_wdata; end
      if (u_if.reg_re) begin re_n++; re_a = u_if.reg_addr; end
      if (u_if.reg_we && u_if.reg_re) both_n++;
      if (u_if.start_tx) begin tx_n++; tx_b = u_if.byte_tx; tx_c = cyc; end
      if (u_if.frame_err) begin fe_n++; fe_c = cyc; end
   end

   int n_chk = 0, n_fail = 0;
   int last_cyc = 0;

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      u_if.byte_rx     = b;
      u_if.new_byte_rx = 1'b1;
      last_cyc         = cyc;
      @(negedge clk);
      u_if.new_byte_rx = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         #2;
         if (!u_if.busy) break;
      end
      check({name, "_idle"}, int'(u_if.busy), 0);
   endtask

   typedef struct {
      logic [31:0] bytes;   // first byte in [31:24]
      int          n;
      logic [7:0]  rd;
      int          we, re, fe, tx;
      logic [7:0]  txb, addr, wd;
   } vec_t;

   function automatic vec_t mk(logic [31:0] b, int n, logic [7:0] rd, int we, int re,
                               int fe, logic [7:0] txb, logic [7:0] addr, logic [7:0] wd);
      vec_t v;
      v.bytes = b; v.n = n; v.rd = rd; v.we = we; v.re = re; v.fe = fe; v.tx = 1;
      v.txb = txb; v.addr = addr; v.wd = wd;
      return v;
   endfunction

   task automatic apply(input vec_t v, input string name);
      int we0, re0, fe0, tx0;
      we0 = we_n; re0 = re_n; fe0 = fe_n; tx0 = tx_n;
      rd_val = v.rd;
      for (int j = 0; j < v.n; j++) send_byte(v.bytes[31-8*j -: 8]);
      wait_idle(name);
      repeat (2) @(negedge clk);
      check({name, "_we"}, we_n - we0, v.we);
      check({name, "_re"}, re_n - re0, v.re);
      check({name, "_ferr"}, fe_n - fe0, v.fe);
      check({name, "_tx"}, tx_n - tx0, v.tx);
      if (v.tx == 1) check({name, "_txbyte"}, int'(tx_b), int'(v.txb));
      if (v.we == 1) begin
         check({name, "_waddr"}, int'(we_a), int'(v.addr));
         check({name, "_wdata"}, int'(we_d), int'(v.wd));
      end
      if (v.re == 1) check({name, "_raddr"}, int'(re_a), int'(v.addr));
   endtask

   task automatic check_reset_vals(input string name);
      check({name, "_byte_tx"}, int'(u_if.byte_tx), 0);
      check({name, "_start_tx"}, int'(u_if.start_tx), 0);
      check({name, "_reg_addr"}, int'(u_if.reg_addr), 0);
      check({name, "_reg_wdata"}, int'(u_if.reg_wdata), 0);
      check({name, "_reg_we"}, int'(u_if.reg_we), 0);
      check({name, "_reg_re"}, int'(u_if.reg_re), 0);
      check({name, "_frame_err"}, int'(u_if.frame_err), 0);
      check({name, "_busy"}, int'(u_if.busy), 0);
   endtask

`ifdef UART_BRIDGE_CHECKSUM_EN
   localparam int NV = 6;
`else
   localparam int NV = 6;
`endif
   vec_t vecs[NV];

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int s, we0, re0, fe0, tx0, stray, unstable;
      logic [7:0] cs_r01, cs_w2033;
`ifdef UART_BRIDGE_CHECKSUM_EN
      vecs[0] = mk(32'h5710A5E2, 4, 8'h00, 1, 0, 0, 8'h4B, 8'h10, 8'hA5);
      vecs[1] = mk(32'h52227000, 3, 8'h3C, 0, 1, 0, 8'h3C, 8'h22, 8'h00);
      vecs[2] = mk(32'h41000000, 1, 8'h00, 0, 0, 1, 8'h45, 8'h00, 8'h00);
      vecs[3] = mk(32'h57FF00A8, 4, 8'h00, 1, 0, 0, 8'h4B, 8'hFF, 8'h00);
      vecs[4] = mk(32'h5280D200, 3, 8'h00, 0, 1, 0, 8'h00, 8'h80, 8'h00);
      vecs[5] = mk(32'h5710A500, 4, 8'h00, 0, 0, 1, 8'h45, 8'h00, 8'h00);
      cs_r01   = 8'h53;
      cs_w2033 = 8'h44;
`else
      vecs[0] = mk(32'h5710A500, 3, 8'h00, 1, 0, 0, 8'h4B, 8'h10, 8'hA5);
      vecs[1] = mk(32'h52220000, 2, 8'h3C, 0, 1, 0, 8'h3C, 8'h22, 8'h00);
      vecs[2] = mk(32'h41000000, 1, 8'h00, 0, 0, 1, 8'h45, 8'h00, 8'h00);
      vecs[3] = mk(32'h57FF0000, 3, 8'h00, 1, 0, 0, 8'h4B, 8'hFF, 8'h00);
      vecs[4] = mk(32'h52800000, 2, 8'h00, 0, 1, 0, 8'h00, 8'h80, 8'h00);
      vecs[5] = mk(32'h00000000, 1, 8'h00, 0, 0, 1, 8'h45, 8'h00, 8'h00);
      cs_r01   = 8'h00;
      cs_w2033 = 8'h00;
`endif
      u_if.byte_rx     = 8'h00;
      u_if.new_byte_rx = 1'b0;

      repeat (3) @(negedge clk);
      #2;
      check_reset_vals("reset");
      @(negedge clk);
      arst = 1'b0;
      repeat (2) @(negedge clk);

      for (int i = 0; i < NV; i++) apply(vecs[i], $sformatf("vec%0d", i));

      // Read latency: last frame strobe to start_tx
      rd_val = 8'h3C;
      re0 = re_n; tx0 = tx_n;
      send_byte(8'h52);
      send_byte(8'h22);
`ifdef UART_BRIDGE_CHECKSUM_EN
      send_byte(8'h70);
`endif
      s = last_cyc;
      wait_idle("lat");
      check("lat_cycles", tx_c - s, 4);
      check("lat_txbyte", int'(tx_b), 8'h3C);
      check("lat_re", re_n - re0, 1);
      check("lat_tx", tx_n - tx0, 1);

      // Timeout mid-frame, then a normal read
      we0 = we_n; fe0 = fe_n; tx0 = tx_n;
      send_byte(8'h57);
      send_byte(8'h10);
      s = last_cyc;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         #2;
         if (fe_n != fe0) break;
      end
      check("tmo_ferr", fe_n - fe0, 1);
      check("tmo_cycle", fe_c - s, 100);
      repeat (3) @(negedge clk);
      check("tmo_busy", int'(u_if.busy), 0);
      check("tmo_notx", tx_n - tx0, 0);
      check("tmo_nowe", we_n - we0, 0);
      rd_val = 8'h5A;
      send_byte(8'h52);
      send_byte(8'h01);
`ifdef UART_BRIDGE_CHECKSUM_EN
      send_byte(cs_r01);
`endif
      wait_idle("post_tmo");
      check("post_tmo_txbyte", int'(tx_b), 8'h5A);
      check("post_tmo_raddr", int'(re_a), 8'h01);
      check("post_tmo_tx", tx_n - tx0, 1);

      // PHY busy during SEND, stray byte injected
      we0 = we_n; fe0 = fe_n; tx0 = tx_n;
      stray = 0; unstable = 0;
      hold_done = 1'b1;
      send_byte(8'h57);
      send_byte(8'h20);
      send_byte(8'h33);
`ifdef UART_BRIDGE_CHECKSUM_EN
      send_byte(cs_w2033);
`endif
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         u_if.byte_rx     = 8'h99;
         u_if.new_byte_rx = (i == 4);
         #2;
         if (u_if.start_tx) stray++;
         if (u_if.byte_tx != 8'h4B) unstable++;
      end
      @(negedge clk);
      u_if.new_byte_rx = 1'b0;
      check("hold_nostart", stray, 0);
      check("hold_stable", unstable, 0);
      check("hold_busy", int'(u_if.busy), 1);
      hold_done = 1'b0;
      wait_idle("hold");
      check("hold_tx", tx_n - tx0, 1);
      check("hold_txbyte", int'(tx_b), 8'h4B);
      check("hold_we", we_n - we0, 1);
      check("hold_waddr", int'(we_a), 8'h20);
      check("hold_ferr", fe_n - fe0, 0);

      // Asynchronous reset mid-frame
      send_byte(8'h57);
      send_byte(8'h10);
      @(negedge clk);
      arst = 1'b1;
      #1;
      check_reset_vals("arst");
      @(negedge clk);
      arst = 1'b0;
      repeat (2) @(negedge clk);
      apply(vecs[0], "after_arst");

      check("we_re_overlap", both_n, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
